// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU datapath among N_REQ requesters.
// Registered one-hot grant, binary index for the ALU muxes, optional hold limit.
module alu_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, GRANTED} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] hold_q,  hold_d;

    logic [IDX_W:0]   pick;
    logic [IDX_W-1:0] idx_nxt;
    logic [N_REQ-1:0] others;

    // Rotated find-first-set: lowest offset from s wins; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] s
    );
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(s) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (r[j]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    // State register: all arbitration state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: grant, release/handoff, forced rotation, hold counting.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        pick    = '0;
        idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        others  = req & ~gnt_q;
        unique case (state_q)
            IDLE: begin
                pick = rr_pick(req, ptr_q);
                if (pick[IDX_W]) begin
                    state_d = GRANTED;
                    idx_d   = pick[IDX_W-1:0];
                    gnt_d   = N_REQ'(1) << pick[IDX_W-1:0];
                    hold_d  = '0;
                end
            end
            GRANTED: begin
                if (!req[idx_q]) begin
                    ptr_d  = idx_nxt;
                    hold_d = '0;
                    pick   = rr_pick(req, idx_nxt);
                    if (pick[IDX_W]) begin
                        idx_d = pick[IDX_W-1:0];
                        gnt_d = N_REQ'(1) << pick[IDX_W-1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LIM)) begin
                    hold_d = '0;
                    if (others != '0) begin
                        ptr_d = idx_nxt;
                        pick  = rr_pick(others, idx_nxt);
                        idx_d = pick[IDX_W-1:0];
                        gnt_d = N_REQ'(1) << pick[IDX_W-1:0];
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt       = gnt_q;
        gnt_valid = |gnt_q;
        gnt_idx   = idx_q;
        hold_cnt  = hold_q;
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: two instances (hold limit 4 and unlimited)
// checked every cycle against a queue-free behavioural model.
module tb_alu_rr_arbiter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;

    logic [7:0] gnt_a, gnt_b;
    logic       gv_a, gv_b;
    logic [2:0] idx_a, idx_b;
    logic [3:0] hc_a, hc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(4), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt_a), .gnt_valid(gv_a), .gnt_idx(idx_a), .hold_cnt(hc_a)
    );

    alu_rr_arbiter #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(0), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt_b), .gnt_valid(gv_b), .gnt_idx(idx_b), .hold_cnt(hc_b)
    );

    typedef struct {
        int g;
        int idx;
        int ptr;
        int hold;
    } mst_t;

    mst_t ma, mb;

    function automatic int scan(input logic [7:0] r, input int start);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic mst_t mstep(input mst_t s, input logic [7:0] r,
                                   input int mh);
        mst_t n;
        int c;
        logic [7:0] oth;
        n = s;
        if (s.g < 0) begin
            c = scan(r, s.ptr);
            if (c >= 0) begin
                n.g = c; n.idx = c; n.hold = 0;
            end
        end else if (!r[s.g]) begin
            n.ptr = (s.g + 1) % N;
            n.hold = 0;
            c = scan(r, n.ptr);
            n.g = c;
            if (c >= 0) n.idx = c;
        end else if (mh != 0 && s.hold == mh - 1) begin
            n.hold = 0;
            oth = r & ~(8'(1) << s.g);
            if (oth != 0) begin
                n.ptr = (s.g + 1) % N;
                n.g = scan(oth, n.ptr);
                n.idx = n.g;
            end
        end else begin
            n.hold = (s.hold >= 15) ? 15 : s.hold + 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] mgnt(input mst_t s);
        return (s.g < 0) ? 8'h00 : 8'(1) << s.g;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= '{g: -1, idx: 0, ptr: 0, hold: 0};
            mb <= '{g: -1, idx: 0, ptr: 0, hold: 0};
        end else begin
            ma <= mstep(ma, req, 4);
            mb <= mstep(mb, req, 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit onehot0(input logic [7:0] v);
        return (v & (v - 8'd1)) == 8'd0;
    endfunction

    // Per-cycle compare against the model plus structural invariants.
    always @(negedge clk) begin
        chk("a.gnt", int'(gnt_a), int'(mgnt(ma)));
        chk("a.valid", int'(gv_a), int'(ma.g >= 0));
        chk("a.idx", int'(idx_a), ma.idx);
        chk("a.hold", int'(hc_a), ma.hold);
        chk("b.gnt", int'(gnt_b), int'(mgnt(mb)));
        chk("b.valid", int'(gv_b), int'(mb.g >= 0));
        chk("b.idx", int'(idx_b), mb.idx);
        chk("b.hold", int'(hc_b), mb.hold);
        chk("a.onehot", int'(onehot0(gnt_a)), 1);
        chk("b.onehot", int'(onehot0(gnt_b)), 1);
        chk("a.vld_or", int'(gv_a), int'(|gnt_a));
        if (gv_a) chk("a.idx_match", int'(gnt_a), int'(8'(1) << idx_a));
        if (gv_b) chk("b.idx_match", int'(gnt_b), int'(8'(1) << idx_b));
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.gnt", int'(gnt_a), 'h00);
        chk("rst.idx", int'(idx_a), 0);
        chk("rst.hold", int'(hc_a), 0);

        // Reset mid-grant, then restart from pointer 0.
        req = 8'h04;
        @(negedge clk);
        chk("t1.gnt", int'(gnt_a), 'h04);
        #2 reset = 1'b1;
        #1;
        chk("t1.async_gnt", int'(gnt_a), 'h00);
        chk("t1.async_vld", int'(gv_a), 0);
        @(negedge clk);
        reset = 1'b0;
        req = 8'h84;
        @(negedge clk);
        chk("t1.restart", int'(gnt_a), 'h04);

        // Single requester held; hold window restarts every 4 cycles.
        do_reset();
        req = 8'h04;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2.gnt", int'(gnt_a), 'h04);
            chk("t2.idx", int'(idx_a), 2);
            chk("t2.hold", int'(hc_a), i % 4);
        end

        // Handoff from 2 to 5 without an idle gap.
        req = 8'h24;
        @(negedge clk);
        chk("t3.keep", int'(gnt_a), 'h04);
        req = 8'h20;
        @(negedge clk);
        chk("t3.gnt", int'(gnt_a), 'h20);
        chk("t3.idx", int'(idx_a), 5);
        chk("t3.vld", int'(gv_a), 1);

        // Wrap-around: scan 6,7,0 then release 0 gives 3.
        req = 8'h09;
        @(negedge clk);
        chk("t4.wrap", int'(gnt_a), 'h01);
        req = 8'h08;
        @(negedge clk);
        chk("t4.next", int'(gnt_a), 'h08);
        req = 8'h00;
        @(negedge clk);
        chk("t4.idle", int'(gv_a), 0);
        chk("t4.idx_hold", int'(idx_a), 3);

        // Forced rotation with everyone requesting.
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            chk("t5.rot", int'(gnt_a), int'(8'(1) << ((i / 4) % 8)));
            chk("t5.unlim", int'(gnt_b), 'h01);
        end

        // Unlimited hold saturates the counter.
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6.gnt", int'(gnt_b), 'h01);
            chk("t6.hold", int'(hc_b), (i > 15) ? 15 : i);
        end

        req = 8'h00;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
